ram_arbitro_2p: RTL and testbench

- Two-requester arbiter and sequencer for a shared single-port RAM (2 words x 8 bits by default).
- Accepts level-sensitive requests from ports A and B and grants one at a time, round-robin on conflict.
- Drives one synchronous RAM access per grant, returns read data and a one-cycle ack.
- Sits between two datapath clients and the RAM. It is the only master on the RAM port.

---
 rtl/ram_arbitro_2p_if.sv | 20 ++
 rtl/ram_arbitro_2p.sv | 97 +++++++++
 tb/tb_ram_arbitro_2p.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ram_arbitro_2p_if.sv
// ram_arbitro_2p_if: requester A/B and RAM-side signals of the two-port RAM arbiter
interface ram_arbitro_2p_if #(parameter int DATA_W = 8, parameter int ADDR_W = 1);
  logic              req_a, we_a, ack_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] dados_in_a, dados_out_a;
  logic              req_b, we_b, ack_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] dados_in_b, dados_out_b;
  logic              mem_en, mem_we, ocupado;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dados_in, mem_dados_out;
  modport slave (
    input  req_a, we_a, addr_a, dados_in_a, req_b, we_b, addr_b, dados_in_b, mem_dados_out,
    output ack_a, dados_out_a, ack_b, dados_out_b, mem_en, mem_we, mem_addr, mem_dados_in, ocupado
  );
  modport master (
    output req_a, we_a, addr_a, dados_in_a, req_b, we_b, addr_b, dados_in_b, mem_dados_out,
    input  ack_a, dados_out_a, ack_b, dados_out_b, mem_en, mem_we, mem_addr, mem_dados_in, ocupado
  );
endinterface

// File: rtl/ram_arbitro_2p.sv
// ram_arbitro_2p: round-robin arbiter/sequencer for a shared single-port RAM, 4 cycles per access.
// Optional per-port transaction counters with ARB_ESTATISTICA_EN.
module ram_arbitro_2p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1
) (
  input logic clk,
  input logic rst_n,
  ram_arbitro_2p_if.slave bus
`ifdef ARB_ESTATISTICA_EN
  ,
  input  logic        limpa_cont,
  output logic [15:0] cont_a,
  output logic [15:0] cont_b
`endif
);
  typedef enum logic [1:0] {IDLE, ACESSO, ESPERA, RESP} state_t;
  state_t state_q, state_d;
  logic ultimo_q, ultimo_d, gnt_q, gnt_d, we_q, we_d, win_b;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d, dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  // ultimo/gnt: 0 = A, 1 = B
  assign win_b = bus.req_b & (~bus.req_a | ~ultimo_q);
  always_comb begin
    state_d  = state_q;
    ultimo_d = ultimo_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    case (state_q)
      IDLE: if (bus.req_a | bus.req_b) begin
        state_d = ACESSO;
        gnt_d   = win_b;
        we_d    = win_b ? bus.we_b : bus.we_a;
        addr_d  = win_b ? bus.addr_b : bus.addr_a;
        din_d   = win_b ? bus.dados_in_b : bus.dados_in_a;
      end
      ACESSO: state_d = ESPERA;
      ESPERA: begin
        state_d  = RESP;
        dout_a_d = (!we_q && !gnt_q) ? bus.mem_dados_out : dout_a_q;
        dout_b_d = (!we_q &&  gnt_q) ? bus.mem_dados_out : dout_b_q;
      end
      default: begin
        state_d  = IDLE;
        ultimo_d = gnt_q;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ultimo_q <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      state_q  <= state_d;
      ultimo_q <= ultimo_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
    end
  end
  assign bus.mem_en       = state_q == ACESSO;
  assign bus.mem_we       = (state_q == ACESSO) & we_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_dados_in = din_q;
  assign bus.ack_a        = (state_q == RESP) & ~gnt_q;
  assign bus.ack_b        = (state_q == RESP) & gnt_q;
  assign bus.dados_out_a  = dout_a_q;
  assign bus.dados_out_b  = dout_b_q;
  assign bus.ocupado      = state_q != IDLE;
`ifdef ARB_ESTATISTICA_EN
  logic [15:0] cont_a_q, cont_b_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_a_q <= '0;
      cont_b_q <= '0;
    end else begin
      cont_a_q <= limpa_cont ? 16'd0 : cont_a_q + 16'(bus.ack_a);
      cont_b_q <= limpa_cont ? 16'd0 : cont_b_q + 16'(bus.ack_b);
    end
  end
  assign cont_a = cont_a_q;
  assign cont_b = cont_b_q;
`endif
endmodule

// File: tb/tb_ram_arbitro_2p.sv
// tb_ram_arbitro_2p: directed vectors for ram_arbitro_2p with a 2-word RAM model.
// Inputs change and outputs are checked on the falling edge.
module tb_ram_arbitro_2p;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0, n_bad = 0;
  logic [7:0] ram [2];
  ram_arbitro_2p_if #(.DATA_W(8), .ADDR_W(1)) bus();
`ifdef ARB_ESTATISTICA_EN
  logic limpa_cont = 1'b0;
  logic [15:0] cont_a, cont_b;
  ram_arbitro_2p #(.DATA_W(8), .ADDR_W(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
    .limpa_cont(limpa_cont), .cont_a(cont_a), .cont_b(cont_b));
`else
  ram_arbitro_2p #(.DATA_W(8), .ADDR_W(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_dados_in;
      else bus.mem_dados_out <= ram[bus.mem_addr];
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
`ifdef ARB_ESTATISTICA_EN
  task automatic txn(input bit b);
    if (b) bus.req_b = 1'b1; else bus.req_a = 1'b1;
    repeat (3) nxt();
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    nxt();
  endtask
`endif
  initial begin
    ram[0] = 8'h00;
    ram[1] = 8'h00;
    bus.mem_dados_out = 8'h00;
    {bus.req_a, bus.we_a, bus.addr_a, bus.dados_in_a} = '0;
    {bus.req_b, bus.we_b, bus.addr_b, bus.dados_in_b} = '0;
    nxt();
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_din", bus.mem_dados_in, 0);
    chk("rst_acks", {bus.ack_a, bus.ack_b}, 0);
    chk("rst_douts", {bus.dados_out_a, bus.dados_out_b}, 0);
    chk("rst_ocupado", bus.ocupado, 0);
    rst_n = 1'b1;
    nxt();
    // write A: 0xA5 -> word 1
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 1'b1; bus.dados_in_a = 8'hA5;
    chk("wa_n_mem_en", bus.mem_en, 0);
    nxt();
    chk("wa_n1_mem", {bus.mem_en, bus.mem_we, 7'(bus.mem_addr), bus.mem_dados_in}, {1'b1, 1'b1, 7'd1, 8'hA5});
    chk("wa_n1_ocupado", bus.ocupado, 1);
    nxt();
    chk("wa_n2_mem", {bus.mem_en, bus.mem_we, 7'(bus.mem_addr), bus.mem_dados_in}, {1'b0, 1'b0, 7'd1, 8'hA5});
    chk("wa_n2_ack", {bus.ack_a, bus.ack_b}, 0);
    nxt();
    chk("wa_n3_ack", {bus.ack_a, bus.ack_b}, 2'b10);
    bus.req_a = 1'b0;
    nxt();
    chk("wa_n4_idle", {bus.ack_a, bus.ack_b, bus.ocupado, bus.mem_en}, 0);
    // read B from word 1
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 1'b1;
    nxt();
    chk("rb_n1_mem", {bus.mem_en, bus.mem_we, 7'(bus.mem_addr)}, {1'b1, 1'b0, 7'd1});
    nxt();
    chk("rb_n2_ack", {bus.ack_a, bus.ack_b}, 0);
    nxt();
    chk("rb_n3_ack", {bus.ack_a, bus.ack_b}, 2'b01);
    chk("rb_n3_dout_b", bus.dados_out_b, 8'hA5);
    chk("rb_n3_dout_a", bus.dados_out_a, 8'h00);
    bus.req_b = 1'b0;
    nxt();
    chk("rb_n4_ocupado", bus.ocupado, 0);
    // tie after reset: A, B, A, B
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 1'b1;
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 1'b0;
    chk("tie_n_ocupado", bus.ocupado, 0);
    for (int i = 1; i <= 15; i++) begin
      nxt();
      chk($sformatf("tie_n%0d_ack_a", i), bus.ack_a, (i == 3 || i == 11) ? 1 : 0);
      chk($sformatf("tie_n%0d_ack_b", i), bus.ack_b, (i == 7 || i == 15) ? 1 : 0);
      chk($sformatf("tie_n%0d_ocupado", i), bus.ocupado, (i % 4 != 0) ? 1 : 0);
    end
    chk("tie_dout_a", bus.dados_out_a, 8'hA5);
    chk("tie_dout_b", bus.dados_out_b, 8'h00);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    nxt();
    // B arrives while A writes 0x3C -> word 0
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 1'b0; bus.dados_in_a = 8'h3C;
    nxt();
    chk("busy_n1_mem", {bus.mem_en, bus.mem_we}, 2'b11);
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 1'b0;
    nxt();
    nxt();
    chk("busy_n3_ack", {bus.ack_a, bus.ack_b}, 2'b10);
    bus.req_a = 1'b0;
    nxt();
    chk("busy_n4_ocupado", bus.ocupado, 0);
    nxt();
    chk("busy_n5_mem", {bus.mem_en, bus.mem_we, 7'(bus.mem_addr)}, {1'b1, 1'b0, 7'd0});
    nxt();
    chk("busy_n6_ack", {bus.ack_a, bus.ack_b}, 0);
    nxt();
    chk("busy_n7_ack", {bus.ack_a, bus.ack_b}, 2'b01);
    chk("busy_n7_dout_b", bus.dados_out_b, 8'h3C);
    bus.req_b = 1'b0;
    nxt();
    // reset during ESPERA of an A read
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 1'b0;
    nxt();
    chk("mid_n1_mem_en", bus.mem_en, 1);
    nxt();
    rst_n = 1'b0;
    bus.req_a = 1'b0;
    #1;
    chk("mid_rst_mem", {bus.mem_en, bus.mem_we, bus.ocupado}, 0);
    chk("mid_rst_acks", {bus.ack_a, bus.ack_b}, 0);
    chk("mid_rst_douts", {bus.dados_out_a, bus.dados_out_b}, 0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk($sformatf("mid_post%0d_acks", i), {bus.ack_a, bus.ack_b, bus.ocupado}, 0);
    end
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    repeat (3) nxt();
    chk("mid_tie_ack", {bus.ack_a, bus.ack_b}, 2'b10);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    nxt();
`ifdef ARB_ESTATISTICA_EN
    rst_n = 1'b0;
    nxt();
    chk("cnt_rst", {cont_a, cont_b}, 0);
    rst_n = 1'b1;
    nxt();
    txn(0); txn(0); txn(0); txn(1); txn(1);
    chk("cnt_a3", cont_a, 3);
    chk("cnt_b2", cont_b, 2);
    limpa_cont = 1'b1;
    nxt();
    limpa_cont = 1'b0;
    chk("cnt_clear", {cont_a, cont_b}, 0);
    dut.cont_a_q = 16'hFFFF;
    txn(0);
    chk("cnt_wrap", cont_a, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
